// File: rtl/cam_capture.sv
// Camera frame grabber: turns an RGB565 byte stream into RGB444 frame-buffer writes for one frame per capture request.
// Latency: 1 cycle input register + 1 cycle to assemble the pixel; the write strobe follows the low byte's register stage by one cycle.
// Backpressure: none. The camera cannot be stalled, so the frame buffer must accept one write every other cycle.
//
// Ports:
//   clk, rst                      - camera PCLK, synchronous active-high reset
//   VSYNC, HREF, D                - camera frame sync, line valid and data byte (RGB565, high byte first)
//   CBtn                          - capture request (level); a registered 0->1 edge while idle arms one capture
//   DP_RAM_addr_in/data_in/regW   - frame-buffer write port, one strobe per complete pixel
//   busy, done, overflow          - capture in progress, end-of-frame pulse, sticky "frame had too many pixels"
module cam_capture #(
    parameter int H_PIX = 160,
    parameter int V_LIN = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    input  logic        CBtn,
    output logic [14:0] DP_RAM_addr_in,
    output logic [11:0] DP_RAM_data_in,
    output logic        DP_RAM_regW,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [14:0] MAX_ADDR = 15'(H_PIX * V_LIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        WAIT_FRAME,
        BYTE_HI,
        BYTE_LO,
        FINISH
    } state_t;

    state_t      r_state;

    // Input register stage plus one-cycle-old copies for edge detection
    logic        r_vsync;
    logic        r_vsync_d;
    logic        r_href;
    logic [7:0]  r_d;
    logic        r_cbtn;
    logic        r_cbtn_d;
    logic        r_post_rst;

    logic [7:0]  r_hi;
    logic [14:0] r_waddr;
    logic        r_full;

    logic        w_cbtn_rise;
    logic        w_vs_rise;
    logic        w_vs_fall;
    logic [11:0] w_pix;

    assign w_cbtn_rise = r_cbtn & ~r_cbtn_d;
    assign w_vs_rise   = r_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~r_vsync & r_vsync_d;
    // RGB565 -> RGB444: top 4 bits of each channel; green straddles the byte boundary
    assign w_pix       = {r_hi[7:4], r_hi[2:0], r_d[7], r_d[4:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync    <= 1'b0;
            r_vsync_d  <= 1'b0;
            r_href     <= 1'b0;
            r_d        <= 8'd0;
            r_cbtn     <= 1'b0;
            // Treat the button as already high coming out of reset so a button
            // held through reset release does not look like a fresh press.
            r_cbtn_d   <= 1'b1;
            r_post_rst <= 1'b1;
        end else begin
            r_vsync    <= VSYNC;
            r_vsync_d  <= r_vsync;
            r_href     <= HREF;
            r_d        <= D;
            r_cbtn     <= CBtn;
            // r_cbtn still holds its reset value in the first cycle; mask it out
            r_cbtn_d   <= r_cbtn | r_post_rst;
            r_post_rst <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            DP_RAM_addr_in <= 15'd0;
            DP_RAM_data_in <= 12'd0;
            DP_RAM_regW    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            r_hi           <= 8'd0;
            r_waddr        <= 15'd0;
            r_full         <= 1'b0;
        end else begin
            DP_RAM_regW <= 1'b0;
            done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cbtn_rise) begin
                        r_state  <= WAIT_VS;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    // Start on a clean frame boundary, never mid-frame
                    if (w_vs_fall) begin
                        r_state        <= WAIT_FRAME;
                        r_waddr        <= 15'd0;
                        r_full         <= 1'b0;
                        DP_RAM_addr_in <= 15'd0;
                    end
                end
                WAIT_FRAME, BYTE_HI: begin
                    if (w_vs_rise) begin
                        r_state <= FINISH;
                    end else if (r_href) begin
                        r_hi    <= r_d;
                        r_state <= BYTE_LO;
                    end else begin
                        r_state <= WAIT_FRAME;
                    end
                end
                BYTE_LO: begin
                    // Frame end wins over a low byte arriving in the same cycle
                    if (w_vs_rise) begin
                        r_state <= FINISH;
                    end else if (r_href) begin
                        r_state <= BYTE_HI;
                        if (r_full) begin
                            overflow <= 1'b1;
                        end else begin
                            DP_RAM_regW    <= 1'b1;
                            DP_RAM_data_in <= w_pix;
                            DP_RAM_addr_in <= r_waddr;
                            // Last legal address: stop counting so the output holds it
                            if (r_waddr == MAX_ADDR) begin
                                r_full <= 1'b1;
                            end else begin
                                r_waddr <= r_waddr + 15'd1;
                            end
                        end
                    end else begin
                        // Line ended on an odd byte: drop the held high byte
                        r_state <= WAIT_FRAME;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: directed and random frames against a pixel-list model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cam_capture;

    localparam int MAXA = 160 * 120 - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  D;
    logic        CBtn;
    logic [14:0] DP_RAM_addr_in;
    logic [11:0] DP_RAM_data_in;
    logic        DP_RAM_regW;
    logic        busy;
    logic        done;
    logic        overflow;

    cam_capture #(.H_PIX(160), .V_LIN(120)) dut (
        .clk            (clk),
        .rst            (rst),
        .VSYNC          (VSYNC),
        .HREF           (HREF),
        .D              (D),
        .CBtn           (CBtn),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_data_in (DP_RAM_data_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [14:0] last_addr = '0;

    // Model: expected {addr, rgb444} writes, pixel index within frame, overflow flag
    logic [26:0] exp_q[$];
    int          m_n;
    bit          m_ovf;
    logic [7:0]  line_q[$];
    logic [26:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    task automatic model_begin();
        m_n   = 0;
        m_ovf = 1'b0;
    endtask

    // Pixel n of the frame lands at address n; anything past the last address is overflow
    task automatic model_pixel(input logic [7:0] hi, input logic [7:0] lo);
        if (m_n <= MAXA) exp_q.push_back({15'(m_n), rgb444(hi, lo)});
        else m_ovf = 1'b1;
        m_n++;
    endtask

    always @(negedge clk) begin
        if (DP_RAM_regW === 1'b1) begin
            wr_cnt++;
            last_addr = DP_RAM_addr_in;
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(DP_RAM_regW), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr", 32'({DP_RAM_addr_in, DP_RAM_data_in}), 32'(mon_e));
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input bit keep_high);
        CBtn = 1'b1;
        repeat (4) tick();
        chk("busy_armed", 32'(busy), 32'd1);
        if (!keep_high) CBtn = 1'b0;
        VSYNC = 1'b0;
        model_begin();
        repeat (3) tick();
    endtask

    task automatic send_line(input int gap);
        for (int i = 0; i < line_q.size(); i++) begin
            HREF = 1'b1;
            D    = line_q[i];
            if (i % 2 == 1) model_pixel(line_q[i-1], line_q[i]);
            tick();
        end
        HREF = 1'b0;
        D    = 8'd0;
        repeat (gap) tick();
    endtask

    task automatic rand_line(input int nbytes);
        line_q.delete();
        for (int i = 0; i < nbytes; i++) line_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // mid=1 raises VSYNC while HREF still presents a byte (partial pixel)
    task automatic end_frame(input bit mid);
        int d0;
        int ea;
        d0    = done_cnt;
        ea    = (m_n == 0) ? 0 : ((m_n - 1 > MAXA) ? MAXA : m_n - 1);
        HREF  = mid;
        D     = 8'($urandom_range(0, 255));
        VSYNC = 1'b1;
        tick();
        HREF  = 1'b0;
        repeat (7) tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ovf_end", 32'(overflow), 32'(m_ovf));
        chk("addr_end", 32'(DP_RAM_addr_in), 32'(ea));
        chk("pending_wr", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_addr"}, 32'(DP_RAM_addr_in), 32'd0);
        chk({pfx, "_data"}, 32'(DP_RAM_data_in), 32'd0);
        chk({pfx, "_regw"}, 32'(DP_RAM_regW), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        rst   = 1'b1;
        VSYNC = 1'b1;
        HREF  = 1'b0;
        CBtn  = 1'b0;
        D     = 8'd0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Single red pixel; button held through the whole frame must not retrigger
        arm(1'b1);
        line_q = '{8'hF8, 8'h00};
        send_line(2);
        end_frame(1'b0);
        repeat (5) tick();
        chk("no_retrig", 32'(busy), 32'd0);
        CBtn = 1'b0;
        repeat (2) tick();

        // Green then blue in one line
        arm(1'b0);
        line_q = '{8'h07, 8'hE0, 8'h00, 8'h1F};
        send_line(2);
        end_frame(1'b0);

        // Odd-length line, then a frame end landing mid-pixel
        arm(1'b0);
        line_q = '{8'hA1, 8'hB2, 8'hC3};
        send_line(2);
        line_q = '{8'h5A};
        send_line(0);
        end_frame(1'b1);

        // Random short frames with button chatter while busy
        for (int f = 0; f < 6; f++) begin
            int nl;
            arm(1'b0);
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                rand_line($urandom_range(0, 21));
                CBtn = 1'($urandom_range(0, 1));
                send_line($urandom_range(1, 3));
            end
            CBtn = 1'b0;
            end_frame(1'($urandom_range(0, 1)));
        end

        // Exactly full frame
        w0 = wr_cnt;
        arm(1'b0);
        for (int l = 0; l < 120; l++) begin
            rand_line(320);
            send_line(2);
        end
        end_frame(1'b0);
        chk("full_writes", 32'(wr_cnt - w0), 32'd19200);
        chk("full_last", 32'(last_addr), 32'(MAXA));

        // Last line one pixel too long
        w0 = wr_cnt;
        arm(1'b0);
        for (int l = 0; l < 120; l++) begin
            rand_line((l == 119) ? 322 : 320);
            send_line(2);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        end_frame(1'b0);
        chk("ovf_writes", 32'(wr_cnt - w0), 32'd19200);
        chk("ovf_last", 32'(last_addr), 32'(MAXA));

        // Reset clears sticky overflow
        rst = 1'b1;
        tick();
        chk("rst_clr_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Reset mid-line with the button held through release
        arm(1'b0);
        rand_line(5);
        HREF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            D = line_q[i];
            if (i % 2 == 1) model_pixel(line_q[i-1], line_q[i]);
            tick();
        end
        CBtn = 1'b1;
        rst  = 1'b1;
        tick();
        chk_all_zero("midrst");
        chk("midrst_pending", 32'(exp_q.size()), 32'd0);
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (3) begin
            D = 8'($urandom_range(0, 255));
            tick();
        end
        rst = 1'b0;
        repeat (4) tick();
        HREF  = 1'b0;
        VSYNC = 1'b1;
        repeat (3) tick();
        VSYNC = 1'b0;
        repeat (3) tick();
        HREF = 1'b1;
        repeat (8) begin
            D = 8'($urandom_range(0, 255));
            tick();
        end
        HREF  = 1'b0;
        VSYNC = 1'b1;
        repeat (8) tick();
        chk("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        // A fresh press resumes capture
        CBtn = 1'b0;
        repeat (2) tick();
        arm(1'b0);
        rand_line(6);
        send_line(2);
        end_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter H_PIX, 160, pixels per line.
REQ-002 SHALL have parameter V_LIN, 120, lines per frame; MAX_ADDR = H_PIX*V_LIN-1 (19199).
REQ-003 SHALL have port clk  input  1  single clock, rising edge; top level ties it to camera PCLK.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port VSYNC  input  1  camera frame sync; high = vertical blanking.
REQ-006 SHALL have port HREF  input  1  camera line valid; high = bytes valid on D.
REQ-007 SHALL have port D  input  8  camera data byte, RGB565, high byte first.
REQ-008 SHALL have port CBtn  input  1  capture request, level, synchronised upstream.
REQ-009 SHALL have port DP_RAM_addr_in  output  15  frame-buffer write address.
REQ-010 SHALL have port DP_RAM_data_in  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-011 SHALL have port DP_RAM_regW  output  1  write strobe, one cycle per pixel.
REQ-012 SHALL have port busy  output  1  high from capture armed until frame end.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-014 SHALL have port overflow  output  1  sticky; pixel count exceeded MAX_ADDR this frame.

Function
REQ-015 SHALL register all inputs except clk once before use (1-cycle input latency).
REQ-016 SHALL implement FSM states IDLE, WAIT_VS, WAIT_FRAME, BYTE_HI, BYTE_LO, FINISH.
REQ-017 IDLE: on CBtn rising edge (registered 0->1) SHALL go WAIT_VS; busy=1, overflow cleared.
REQ-018 WAIT_VS: SHALL wait for VSYNC falling edge, then go WAIT_FRAME with address 0.
REQ-019 WAIT_FRAME: HREF=1 SHALL capture D as high byte and go BYTE_LO; otherwise stay.
REQ-020 BYTE_LO: HREF=1 SHALL capture D as low byte, issue write, go BYTE_HI; HREF=0 SHALL discard held high byte, go WAIT_FRAME.
REQ-021 BYTE_HI: HREF=1 SHALL capture high byte, go BYTE_LO; HREF=0 SHALL go WAIT_FRAME.
REQ-022 Conversion SHALL be R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
REQ-023 DP_RAM_regW SHALL assert the cycle after the low byte is registered, with data and address valid in that same cycle.
REQ-024 First pixel of frame SHALL be written to address 0; address SHALL increment by 1 after each write.
REQ-025 At address MAX_ADDR, last write SHALL occur; further complete pixels SHALL NOT write, address SHALL hold, overflow SHALL set.
REQ-026 VSYNC rising edge in WAIT_FRAME/BYTE_HI/BYTE_LO SHALL discard any partial pixel and go FINISH.
REQ-027 FINISH: SHALL pulse done for one cycle, drop busy, return to IDLE.
REQ-028 CBtn edges while busy=1 SHALL be ignored; CBtn held high SHALL NOT retrigger.
REQ-029 Fewer than MAX_ADDR+1 pixels in a frame SHALL NOT be an error; unwritten addresses keep prior contents.

Reset
REQ-030 rst=1 SHALL force IDLE, DP_RAM_addr_in=0, DP_RAM_data_in=0, DP_RAM_regW=0, busy=0, done=0, overflow=0, input registers 0.
REQ-031 rst mid-frame SHALL abort with no further writes and no done pulse; capture resumes only on new CBtn edge.

Verification
REQ-032 CBtn 0->1, VSYNC fall, one line HREF=1 with bytes F8,00 -> regW at addr 0, data 0xF00.
REQ-033 Bytes 07,E0 then 00,1F in one line -> addr 0 data 0x0F0, addr 1 data 0x00F, two regW pulses.
REQ-034 Full 160x120 frame then VSYNC rise -> 19200 writes, last addr 19199, done pulse once, busy low, overflow 0.
REQ-035 Line of 161 pixels on last line -> writes stop at 19199, overflow=1, address holds 19199.
REQ-036 HREF drops after odd byte; VSYNC rises mid-pixel -> no write for partial pixel, done pulses.
REQ-037 rst asserted mid-line -> all outputs 0 next cycle, no done; CBtn held high through rst release -> stays IDLE.
